// File: rtl/etapa_ejecucion_escritura.sv
// ---------------------------------------------------------------------------
// etapa_ejecucion_escritura
//   Stage directly after the ALU. Each accepted entry has its ARM condition
//   code evaluated against the committed NZCV register. The NZCV register is
//   updated when the entry passes its condition with S set. Every accepted
//   entry, whether it passed or failed, is then queued in a 2-entry in-order
//   FIFO toward register-file writeback.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   valido_entrada       ALU side valid
//   listo_entrada        stage can accept (FIFO not full, registered state only)
//   resultado, flags_alu ALU result and {N,Z,C,V}
//   ALUControl           ALU opcode (1000 add, 1001 sub update C/V)
//   condicion, setFlags  ARM cond field and S bit
//   escribirReg          entry writes a destination register
//   regDestino           destination index
//   valido_salida        FIFO head valid
//   listo_salida         writeback accepts head
//   resultado_salida, destino_salida, escribir_salida, ejecutada_salida
//                        head fields, driven from FIFO storage
//   banderas             committed NZCV register
// ---------------------------------------------------------------------------
module etapa_ejecucion_escritura #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valido_entrada,
    output logic         listo_entrada,
    input  logic [N-1:0] resultado,
    input  logic [3:0]   flags_alu,
    input  logic [3:0]   ALUControl,
    input  logic [3:0]   condicion,
    input  logic         setFlags,
    input  logic         escribirReg,
    input  logic [3:0]   regDestino,
    output logic         valido_salida,
    input  logic         listo_salida,
    output logic [N-1:0] resultado_salida,
    output logic [3:0]   destino_salida,
    output logic         escribir_salida,
    output logic         ejecutada_salida,
    output logic [3:0]   banderas
);

    typedef struct packed {
        logic [N-1:0] res;
        logic [3:0]   dst;
        logic         escr;
        logic         ejec;
    } entrada_t;

    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
        C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
        C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
    } cond_t;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;

    entrada_t    mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;

    logic        push, pop, pasa, actualiza;
    logic        fn, fz, fc, fv;
    logic [3:0]  banderas_sig;
    entrada_t    nueva;

    assign fn = banderas[3];
    assign fz = banderas[2];
    assign fc = banderas[1];
    assign fv = banderas[0];

    // Condition uses committed flags only; flags_alu of the same cycle never
    // bypasses into this decision.
    always_comb begin
        pasa = 1'b0;
        unique case (cond_t'(condicion))
            C_EQ: pasa = fz;
            C_NE: pasa = !fz;
            C_CS: pasa = fc;
            C_CC: pasa = !fc;
            C_MI: pasa = fn;
            C_PL: pasa = !fn;
            C_VS: pasa = fv;
            C_VC: pasa = !fv;
            C_HI: pasa = fc && !fz;
            C_LS: pasa = !fc || fz;
            C_GE: pasa = (fn == fv);
            C_LT: pasa = (fn != fv);
            C_GT: pasa = !fz && (fn == fv);
            C_LE: pasa = fz || (fn != fv);
            C_AL: pasa = 1'b1;
            C_NV: pasa = 1'b0;
            default: pasa = 1'b0;
        endcase
    end

    assign listo_entrada = (count != 2'd2);
    assign valido_salida = (count != 2'd0);
    assign push          = valido_entrada && listo_entrada;
    assign pop           = valido_salida && listo_salida;
    assign actualiza     = push && pasa && setFlags;

    // N/Z always follow the ALU; C/V only carry meaning for add/sub, so
    // logical ops keep the previous C and V.
    always_comb begin
        banderas_sig = banderas;
        if (actualiza) begin
            banderas_sig[3:2] = flags_alu[3:2];
            if (ALUControl == OP_ADD || ALUControl == OP_SUB)
                banderas_sig[1:0] = flags_alu[1:0];
        end
    end

    always_comb begin
        nueva.res  = resultado;
        nueva.dst  = regDestino;
        nueva.escr = escribirReg && pasa;
        nueva.ejec = pasa;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            banderas <= 4'b0000;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            banderas <= banderas_sig;
            if (push) begin
                mem[wr_ptr] <= nueva;
                wr_ptr      <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            // push at count=2 and pop at count=0 are already masked above
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign resultado_salida = mem[rd_ptr].res;
    assign destino_salida   = mem[rd_ptr].dst;
    assign escribir_salida  = mem[rd_ptr].escr;
    assign ejecutada_salida = mem[rd_ptr].ejec;

endmodule

// File: tb/tb_etapa_ejecucion_escritura.sv
module tb_etapa_ejecucion_escritura;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         valido_entrada;
    logic         listo_entrada;
    logic [N-1:0] resultado;
    logic [3:0]   flags_alu;
    logic [3:0]   ALUControl;
    logic [3:0]   condicion;
    logic         setFlags;
    logic         escribirReg;
    logic [3:0]   regDestino;
    logic         valido_salida;
    logic         listo_salida;
    logic [N-1:0] resultado_salida;
    logic [3:0]   destino_salida;
    logic         escribir_salida;
    logic         ejecutada_salida;
    logic [3:0]   banderas;

    etapa_ejecucion_escritura #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .valido_entrada(valido_entrada), .listo_entrada(listo_entrada),
        .resultado(resultado), .flags_alu(flags_alu), .ALUControl(ALUControl),
        .condicion(condicion), .setFlags(setFlags), .escribirReg(escribirReg),
        .regDestino(regDestino), .valido_salida(valido_salida),
        .listo_salida(listo_salida), .resultado_salida(resultado_salida),
        .destino_salida(destino_salida), .escribir_salida(escribir_salida),
        .ejecutada_salida(ejecutada_salida), .banderas(banderas)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [N-1:0] res;
        logic [3:0]   rd;
        logic         wr;
        logic         ex;
    } ment_t;

    ment_t      q[$];
    logic [3:0] mflags;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: predict from pre-edge inputs/model state, then compare.
    task automatic step();
        bit    do_push, do_pop, p;
        ment_t e;
        do_push = reset && valido_entrada && (q.size() < 2);
        do_pop  = reset && listo_salida && (q.size() > 0);
        p       = cond_ok(condicion, mflags);
        e.res = resultado; e.rd = regDestino; e.wr = escribirReg && p; e.ex = p;
        @(posedge clk);
        #1;
        if (!reset) begin
            q.delete();
            mflags = 4'b0000;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(e);
                if (p && setFlags) begin
                    mflags[3:2] = flags_alu[3:2];
                    if (ALUControl == 4'b1000 || ALUControl == 4'b1001)
                        mflags[1:0] = flags_alu[1:0];
                end
            end
        end
        chk("model_valido", valido_salida, q.size() != 0);
        chk("model_listo", listo_entrada, q.size() < 2);
        chk("model_banderas", banderas, mflags);
        if (q.size() != 0) begin
            chk("model_res", resultado_salida, q[0].res);
            chk("model_dst", destino_salida, q[0].rd);
            chk("model_escr", escribir_salida, q[0].wr);
            chk("model_ejec", ejecutada_salida, q[0].ex);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] alu, input logic [3:0] c,
                         input logic s, input logic [3:0] fa, input logic [N-1:0] r,
                         input logic w, input logic [3:0] rd);
        valido_entrada = v; ALUControl = alu; condicion = c; setFlags = s;
        flags_alu = fa; resultado = r; escribirReg = w; regDestino = rd;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0] init;
        logic [3:0] alu;
        logic [3:0] cond;
        logic       s;
        logic [3:0] fa;
        logic [3:0] exp_f;
        logic       exp_ex;
        logic       exp_wr;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input logic [3:0] init, input logic [3:0] alu,
                                input logic [3:0] cond, input logic s, input logic [3:0] fa,
                                input logic [3:0] ef, input logic ex, input logic wr);
        vec_t r;
        r.init = init; r.alu = alu; r.cond = cond; r.s = s; r.fa = fa;
        r.exp_f = ef; r.exp_ex = ex; r.exp_wr = wr;
        return r;
    endfunction

    initial begin
        ment_t a_hd;
        vt[0]  = mk(4'b0010, 4'b0000, 4'hE, 1, 4'b1001, 4'b1010, 1, 1); // AND keeps C,V
        vt[1]  = mk(4'b0110, 4'b1000, 4'hF, 1, 4'b1111, 4'b0110, 0, 0); // never
        vt[2]  = mk(4'b0000, 4'b1000, 4'h0, 1, 4'b0100, 4'b0000, 0, 0); // EQ fails
        vt[3]  = mk(4'b0100, 4'b1001, 4'h0, 1, 4'b1011, 4'b1011, 1, 1); // EQ sub
        vt[4]  = mk(4'b1001, 4'b1000, 4'hA, 0, 4'b0000, 4'b1001, 1, 1); // GE
        vt[5]  = mk(4'b1000, 4'b1000, 4'hB, 1, 4'b0111, 4'b0111, 1, 1); // LT
        vt[6]  = mk(4'b0010, 4'b1000, 4'h8, 0, 4'b0000, 4'b0010, 1, 1); // HI pass
        vt[7]  = mk(4'b0110, 4'b1000, 4'h8, 0, 4'b0000, 4'b0110, 0, 0); // HI fail
        vt[8]  = mk(4'b0100, 4'b0010, 4'h9, 1, 4'b1000, 4'b1000, 1, 1); // LS
        vt[9]  = mk(4'b1001, 4'b1000, 4'hC, 0, 4'b0000, 4'b1001, 1, 1); // GT
        vt[10] = mk(4'b1101, 4'b1000, 4'hD, 0, 4'b0000, 4'b1101, 1, 1); // LE
        vt[11] = mk(4'b0001, 4'b1111, 4'h6, 1, 4'b0110, 4'b0101, 1, 1); // VS, C/V held
        vt[12] = mk(4'b0001, 4'b1000, 4'h7, 1, 4'b1111, 4'b0001, 0, 0); // VC fails
        vt[13] = mk(4'b1000, 4'b1000, 4'h5, 0, 4'b0000, 4'b1000, 0, 0); // PL fails
        vt[14] = mk(4'b0000, 4'b1001, 4'h3, 1, 4'b1111, 4'b1111, 1, 1); // CC

        q.delete();
        mflags = 4'b0000;
        listo_salida = 1'b1;
        drive(1, 4'b1000, 4'hE, 1, 4'b1111, 32'hDEAD, 1, 4'd5);

        // T1: reset with valid asserted stores nothing
        reset = 1'b0;
        step(); step();
        chk("t1_valido", valido_salida, 1'b0);
        chk("t1_banderas", banderas, 4'b0000);
        chk("t1_listo", listo_entrada, 1'b1);
        chk("t1_res", resultado_salida, '0);
        reset = 1'b1;
        valido_entrada = 1'b0;
        step();
        chk("t1_empty", valido_salida, 1'b0);

        // T2
        drive(1, 4'b1001, 4'hE, 1, 4'b0110, 32'd0, 1, 4'd0);
        step();
        chk("t2_banderas", banderas, 4'b0110);
        drive(1, 4'b1000, 4'h0, 0, 4'b0000, 32'd7, 1, 4'd2);
        step();
        chk("t2_eq_escr", escribir_salida, 1'b1);
        chk("t2_eq_dst", destino_salida, 4'd2);
        chk("t2_eq_res", resultado_salida, 32'd7);
        drive(1, 4'b1000, 4'h1, 0, 4'b0000, 32'd9, 1, 4'd3);
        step();
        chk("t2_ne_escr", escribir_salida, 1'b0);
        chk("t2_ne_ejec", ejecutada_salida, 1'b0);
        chk("t2_ne_valido", valido_salida, 1'b1);
        valido_entrada = 1'b0;
        step();

        // Table: set flags with an AL add, then apply the vector entry
        foreach (vt[i]) begin
            valido_entrada = 1'b0;
            step();
            drive(1, 4'b1000, 4'hE, 1, vt[i].init, 32'h100 + i, 1, 4'd1);
            step();
            chk("vec_init", banderas, vt[i].init);
            drive(1, vt[i].alu, vt[i].cond, vt[i].s, vt[i].fa, 32'h200 + i, 1, 4'd4);
            step();
            chk($sformatf("vec%0d_banderas", i), banderas, vt[i].exp_f);
            chk($sformatf("vec%0d_ejec", i), ejecutada_salida, vt[i].exp_ex);
            chk($sformatf("vec%0d_escr", i), escribir_salida, vt[i].exp_wr);
            chk($sformatf("vec%0d_res", i), resultado_salida, 32'h200 + i);
        end
        valido_entrada = 1'b0;
        step();

        // T5: backpressure, A/B fill, C held upstream, drained in order
        listo_salida = 1'b0;
        drive(1, 4'b0000, 4'hE, 0, 4'b0000, 32'hA, 1, 4'd10);
        step();
        drive(1, 4'b0000, 4'hE, 0, 4'b0000, 32'hB, 1, 4'd11);
        step();
        chk("t5_full", listo_entrada, 1'b0);
        drive(1, 4'b0000, 4'hE, 0, 4'b0000, 32'hC, 1, 4'd12);
        step();
        step();
        chk("t5_hold_listo", listo_entrada, 1'b0);
        chk("t5_hold_head", resultado_salida, 32'hA);
        listo_salida = 1'b1;
        step();
        chk("t5_second", resultado_salida, 32'hB);
        step();
        chk("t5_third", resultado_salida, 32'hC);
        chk("t5_third_dst", destino_salida, 4'd12);
        valido_entrada = 1'b0;
        step();
        chk("t5_drained", valido_salida, 1'b0);

        // T6: reset while full
        drive(1, 4'b1001, 4'hE, 1, 4'b1011, 32'h55, 1, 4'd7);
        listo_salida = 1'b0;
        step(); step();
        chk("t6_full", listo_entrada, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        valido_entrada = 1'b0;
        chk("t6_valido", valido_salida, 1'b0);
        chk("t6_banderas", banderas, 4'b0000);
        chk("t6_listo", listo_entrada, 1'b1);
        chk("t6_res", resultado_salida, '0);
        step();
        chk("t6_after", valido_salida, 1'b0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 59) != 0);
            valido_entrada = $urandom_range(0, 3) != 0;
            listo_salida   = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 2))
                0: ALUControl = 4'b1000;
                1: ALUControl = 4'b1001;
                default: ALUControl = 4'($urandom);
            endcase
            condicion   = 4'($urandom);
            setFlags    = 1'($urandom);
            flags_alu   = 4'($urandom);
            resultado   = $urandom;
            escribirReg = 1'($urandom);
            regDestino  = 4'($urandom);
            step();
        end
        a_hd = '0;
        if (a_hd.wr) n_bad++;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
